// File: rtl/reaction_measure_fsm_pkg.sv
// Shared reaction-game definitions: FSM state encodings and default timer width.
// Include-guarded so several game blocks can pull it into one compilation unit.
`ifndef REACTION_MEASURE_FSM_PKG_SV
`define REACTION_MEASURE_FSM_PKG_SV

package reaction_measure_fsm_pkg;

    localparam int TIME_WIDTH_DEF = 11;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_WAIT_DELAY  = 3'd1;
    localparam logic [2:0] ST_MEASURE     = 3'd2;
    localparam logic [2:0] ST_RESULT      = 3'd3;
    localparam logic [2:0] ST_FALSE_START = 3'd4;
    localparam logic [2:0] ST_TIMEOUT     = 3'd5;

endpackage

`endif

// File: rtl/reaction_measure_fsm_edge.sv
// Rising-edge detector for a level already synchronous to clk; rise is combinational from sig_in.
// No backpressure: prev register updates every non-reset cycle, so a held level gives one pulse.
module rising_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/reaction_measure_fsm.sv
// Reaction-time FSM: arms the delay counter, lights the stimulus, times the player's press.
// All outputs registered (one cycle after the deciding input); no backpressure, inputs sampled every cycle.
module reaction_measure_fsm
    import reaction_measure_fsm_pkg::*;
#(
    parameter int TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int TICK_DIV   = 1
) (
    input  logic                  ClockIn,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Button,
    input  logic                  DelayDone,
    output logic                  DelayEnable,
    output logic                  Stimulus,
    output logic [TIME_WIDTH-1:0] Time,
    output logic                  Valid,
    output logic                  FalseStart,
    output logic                  Timeout
);

    localparam int                  PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]    TICK_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_WIDTH-1:0] TIME_MAX = {TIME_WIDTH{1'b1}};

    logic [2:0]            state_q, state_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic                  delay_enable_q, delay_enable_d;
    logic                  stimulus_q, stimulus_d;
    logic                  valid_q, valid_d;
    logic                  false_start_q, false_start_d;
    logic                  timeout_q, timeout_d;
    logic                  press;

    rising_edge_detect u_btn_edge (
        .clk    (ClockIn),
        .rst_n  (Reset),
        .sig_in (Button),
        .rise   (press)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pre_d   = pre_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_WAIT_DELAY;
                end
            end
            ST_WAIT_DELAY: begin
                // A press coinciding with DelayDone is still a false start.
                if (press) begin
                    state_d = ST_FALSE_START;
                    time_d  = '0;
                end else if (DelayDone) begin
                    state_d = ST_MEASURE;
                    time_d  = '0;
                    pre_d   = '0;
                end
            end
            ST_MEASURE: begin
                if (press) begin
                    state_d = ST_RESULT;
                end else if (pre_q == TICK_LAST) begin
                    pre_d = '0;
                    if (time_q == TIME_MAX) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        time_d = time_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            ST_RESULT, ST_FALSE_START, ST_TIMEOUT: begin
                if (Start) begin
                    state_d = ST_WAIT_DELAY;
                    time_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                time_d  = '0;
                pre_d   = '0;
            end
        endcase
    end

    // Output flags follow the next state so they line up with the registered state.
    always_comb begin
        delay_enable_d = (state_d == ST_WAIT_DELAY);
        stimulus_d     = (state_d == ST_MEASURE);
        valid_d        = (state_d == ST_RESULT);
        false_start_d  = (state_d == ST_FALSE_START);
        timeout_d      = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge ClockIn) begin
        if (!Reset) begin
            state_q        <= ST_IDLE;
            time_q         <= '0;
            pre_q          <= '0;
            delay_enable_q <= 1'b0;
            stimulus_q     <= 1'b0;
            valid_q        <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            time_q         <= time_d;
            pre_q          <= pre_d;
            delay_enable_q <= delay_enable_d;
            stimulus_q     <= stimulus_d;
            valid_q        <= valid_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
        end
    end

    assign DelayEnable = delay_enable_q;
    assign Stimulus    = stimulus_q;
    assign Time        = time_q;
    assign Valid       = valid_q;
    assign FalseStart  = false_start_q;
    assign Timeout     = timeout_q;

endmodule

// File: tb/tb_reaction_measure_fsm.sv
// Scoreboard bench: two DUTs (TICK_DIV 1 and 4) share stimulus; a round-level model predicts each outcome.
module tb_reaction_measure_fsm;

    localparam int TW = 11;

    typedef struct packed {
        logic [1:0]    kind;   // 1 valid, 2 false start, 3 timeout
        logic [TW-1:0] tm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, button, delay_done;
    logic de0, st0, v0, f0, t0;
    logic de1, st1, v1, f1, t1;
    logic [TW-1:0] tm0, tm1;

    int n_cmp = 0;
    int n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit prev_any[2];
    bit rnd_st[$];
    bit rnd_btn[$];
    bit rnd_done[$];

    always #5 clk = ~clk;

    reaction_measure_fsm #(.TIME_WIDTH(TW), .TICK_DIV(1)) dut0 (
        .ClockIn(clk), .Reset(rst_n), .Start(start), .Button(button), .DelayDone(delay_done),
        .DelayEnable(de0), .Stimulus(st0), .Time(tm0), .Valid(v0), .FalseStart(f0), .Timeout(t0)
    );

    reaction_measure_fsm #(.TIME_WIDTH(TW), .TICK_DIV(4)) dut1 (
        .ClockIn(clk), .Reset(rst_n), .Start(start), .Button(button), .DelayDone(delay_done),
        .DelayEnable(de1), .Stimulus(st1), .Time(tm1), .Valid(v1), .FalseStart(f1), .Timeout(t1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a DUT raises a result flag, pop and compare the predicted outcome.
    task automatic mon(input int id, input logic de, input logic stim, input logic [TW-1:0] tm,
                       input logic v, input logic f, input logic t);
        logic any;
        exp_t e;
        bit got;
        int kind;
        any = v | f | t;
        if (any && !prev_any[id]) begin
            got = 0;
            e = '0;
            if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
            if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
            if (!got) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut%0d unexpected result: v=%0d f=%0d t=%0d time=%0d, expected no result", id, v, f, t, tm);
            end else begin
                kind = v ? 1 : (f ? 2 : (t ? 3 : 0));
                chk($sformatf("dut%0d result kind", id), kind, 32'(e.kind));
                chk($sformatf("dut%0d result time", id), 32'(tm), 32'(e.tm));
                chk($sformatf("dut%0d flags onehot", id), 32'(v) + 32'(f) + 32'(t), 1);
                chk($sformatf("dut%0d stimulus off in result", id), 32'(stim), 0);
                chk($sformatf("dut%0d delay_enable off in result", id), 32'(de), 0);
            end
        end
        prev_any[id] = any;
    endtask

    always @(negedge clk) begin
        mon(0, de0, st0, tm0, v0, f0, t0);
        mon(1, de1, st1, tm1, v1, f1, t1);
    end

    // Reference: walks the round's per-edge inputs using the game rules, not the RTL structure.
    task automatic model(input int td, output bit has, output exp_t e);
        bit measuring;
        bit prev;
        bit press;
        int k;
        measuring = 0;
        k = 0;
        has = 0;
        e = '0;
        prev = rnd_btn[0];
        for (int i = 1; i < rnd_btn.size(); i++) begin
            press = rnd_btn[i] && !prev;
            prev = rnd_btn[i];
            if (!measuring) begin
                if (press) begin
                    has = 1; e.kind = 2; e.tm = '0;
                    return;
                end
                if (rnd_done[i]) measuring = 1;
            end else begin
                if (press) begin
                    has = 1; e.kind = 1; e.tm = TW'(k / td);
                    return;
                end
                if (k == (1 << TW) * td - 1) begin
                    has = 1; e.kind = 3; e.tm = TW'((1 << TW) - 1);
                    return;
                end
                k++;
            end
        end
    endtask

    task automatic push_e(input bit s, input bit b, input bit d);
        rnd_st.push_back(s);
        rnd_btn.push_back(b);
        rnd_done.push_back(d);
    endtask

    // Modes: 0 press at measure cycle p, 1 press during wait, 2 press with DelayDone,
    // 3 button held from Start then re-pressed at cycle p, 4 no press (timeout), 5 stop mid-measure.
    task automatic build_round(input int mode, input int d, input int p, input bit rs);
        rnd_st.delete(); rnd_btn.delete(); rnd_done.delete();
        push_e(1, (mode == 3), 0);
        for (int i = 0; i < d; i++) push_e(rs && ($urandom_range(0, 3) == 0), (mode == 3), 0);
        if (mode == 1) begin
            push_e(0, 1, 0); push_e(0, 0, 0);
        end else if (mode == 2) begin
            push_e(0, 1, 1); push_e(0, 0, 0);
        end else begin
            push_e(0, (mode == 3), 1);
            if (mode == 0) begin
                for (int k = 0; k < p; k++) push_e(rs && ($urandom_range(0, 3) == 0), 0, 0);
                push_e(0, 1, 0); push_e(0, 0, 0);
            end else if (mode == 3) begin
                push_e(0, 1, 0); push_e(0, 1, 0);
                for (int k = 2; k < p; k++) push_e(0, 0, 0);
                push_e(0, 1, 0); push_e(0, 0, 0);
            end else if (mode == 4) begin
                for (int k = 0; k < (1 << TW) * 4; k++) push_e(0, 0, 0);
            end else begin
                for (int k = 0; k < p; k++) push_e(0, 0, 0);
            end
        end
    endtask

    task automatic issue_and_drive(input int idle);
        bit has;
        exp_t e;
        model(1, has, e);
        if (has) q0.push_back(e);
        model(4, has, e);
        if (has) q1.push_back(e);
        for (int i = 0; i < rnd_st.size(); i++) begin
            start = rnd_st[i];
            button = rnd_btn[i];
            delay_done = rnd_done[i];
            step();
            if (i == 0) begin
                chk("dut0 armed delay_enable", 32'(de0), 1);
                chk("dut1 armed delay_enable", 32'(de1), 1);
                chk("dut0 armed flags cleared", 32'(v0 | f0 | t0), 0);
                chk("dut0 armed time cleared", 32'(tm0), 0);
            end
        end
        start = 0;
        delay_done = 0;
        button = 0;
        for (int i = 0; i < idle; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " dut0 outputs"}, {26'd0, de0, st0, v0, f0, t0, 1'b0} | 32'(tm0), 0);
        chk({tag, " dut1 outputs"}, {26'd0, de1, st1, v1, f1, t1, 1'b0} | 32'(tm1), 0);
    endtask

    initial begin
        int mode;
        rst_n = 0; start = 0; button = 0; delay_done = 0;
        step(); step();
        check_all_zero("reset");
        rst_n = 1;
        step();
        check_all_zero("idle");

        build_round(0, 3, 37, 0); issue_and_drive(3);
        build_round(1, 2, 0, 0);  issue_and_drive(3);
        build_round(2, 4, 0, 0);  issue_and_drive(3);
        build_round(4, 1, 0, 0);  issue_and_drive(3);
        build_round(0, 5, 10, 0); issue_and_drive(3);
        build_round(3, 2, 5, 0);  issue_and_drive(3);

        build_round(5, 0, 20, 0); issue_and_drive(0);
        chk("mid-measure dut0 time", 32'(tm0), 20);
        chk("mid-measure dut1 time", 32'(tm1), 5);
        chk("mid-measure stimulus", 32'(st0 & st1), 1);
        rst_n = 0;
        step();
        check_all_zero("mid-measure reset");
        rst_n = 1;
        step();

        build_round(0, 1, 8, 0); issue_and_drive(2);
        build_round(0, 2, 3, 0); issue_and_drive(2);

        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 3);
            build_round(mode, $urandom_range(0, 6),
                        (mode == 3) ? $urandom_range(3, 60) : $urandom_range(0, 60), 1);
            issue_and_drive($urandom_range(1, 3));
        end

        step(); step();
        chk("dut0 pending results", q0.size(), 0);
        chk("dut1 pending results", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
